sobel_window_scheduler: RTL and testbench
=========================================

Name: sobel_window_scheduler

Overview:
Raster-scan sequencer for the 3x3 Sobel datapath. It accepts one frame of pixels as a valid/ready stream and keeps two line buffers plus a 3x3 shift window. For every interior pixel it issues one packed 72-bit window to the Sobel engine over a valid/ready handshake. It sits between the frame source (DMA/bus) and the Sobel wrapper, so the host no longer has to build windows itself.

Parameters:
IMG_W, 64, frame width in pixels (>=3)
IMG_H, 64, frame height in lines (>=3)
PIX_W, 8, pixel width in bits; window width is 9*PIX_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last window handshake
pix_valid  in  1  input pixel valid
pix_data  in  PIX_W  input pixel, raster order (row 0 col 0 first)
pix_ready  out  1  scheduler accepts pixel this cycle
win_valid  out  1  window register holds a window
win_data  out  9*PIX_W  packed 3x3 window
win_ready  in  1  engine accepts window
win_count  out  16  windows handshaked in the current or last frame

Behaviour:
- Reset (async, active-low): state=IDLE, busy=0, done=0, pix_ready=0, win_valid=0, win_data=0, win_count=0, row/col counters=0. Line-buffer RAM contents are not cleared; they are overwritten before use. A reset mid-frame abandons the frame with no done pulse.
- FSM states IDLE, RUN, FLUSH, DONE.
- IDLE: on start=1, clear counters and win_count, go to RUN, busy=1. start is ignored in any other state.
- RUN: pix_ready = !win_valid || win_ready, so the window register is a one-deep skid. A pixel transfers when pix_valid && pix_ready.
- On each transfer:
  - shift the window left by one column, loading the new column {lb1[col], lb0[col], pix}, top to bottom;
  - write lb1[col] <= lb0[col] and lb0[col] <= pix;
  - advance col, wrapping at IMG_W-1 and incrementing row.
- Window issue: a transfer of the pixel at (row>=2, col>=2) registers a window centred on (row-1, col-1) the next cycle, with win_valid=1. The window is built from the post-shift values. Edge pixels produce no window, so each frame issues (IMG_W-2)*(IMG_H-2) windows.
- Window packing, column-major, MSB first: [71:64]=top-left, middle-left, bottom-left, top-centre, centre, bottom-centre, top-right, middle-right, [7:0]=bottom-right. This is the existing engine bus order.
- Window handshake completes when win_valid && win_ready. win_valid drops unless a new window loads the same cycle. win_count increments by 1 per handshake and saturates at 16'hFFFF.
- win_data and win_valid stay stable while win_valid=1 and win_ready=0.
- Window assembly at row wrap: the window shift register is not flushed. The first two columns of a new row produce no window, so no stale data is issued.
- After the last pixel (IMG_H-1, IMG_W-1) transfers, go to FLUSH with pix_ready=0.
- FLUSH: wait for the final window handshake, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. win_count holds its value until the next start.
- Latency: pixel transfer to win_valid is 1 cycle. Throughput is 1 pixel per cycle when win_ready is held at 1.
- A simultaneous pixel transfer and window handshake in the same cycle is legal. The new window replaces the old one with no bubble.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W default;
  - WIN_W = 9*PIX_W;
  - state enum {IDLE, RUN, FLUSH, DONE};
  - window slot index constants (TL..BR) defining the packing.
- One sub-module, sobel_line_buffer: a single-port IMG_W x PIX_W array with read-before-write at one address per cycle. It is instantiated twice (lb0, lb1).

Test Plan:
- IMG_W=4, IMG_H=4, pixels = r*4+c, win_ready=1 -> first window 72'h00_04_08_01_05_09_02_06_0A one cycle after pixel 10. Exactly 4 windows, last 72'h05_09_0D_06_0A_0E_07_0B_0F. done pulses once, win_count=4.
- Same frame, win_ready low for 5 cycles while win_valid=1 -> pix_ready=0 throughout, win_data held stable, no window lost, final win_count=4.
- pix_valid toggled randomly with a 50% duty cycle, 5x3 image -> 3 windows in raster order, values match the software model, no window emitted for col<2.
- start asserted during RUN -> ignored. win_count is not cleared and the frame completes normally.
- reset asserted after pixel 7 of a 4x4 frame -> all outputs return to reset values immediately with no done pulse. A subsequent start and full frame reproduce the first test's windows.
- Two back-to-back frames (start the cycle after done) -> the second frame's windows are correct, with no data carried over from frame 1.

Source files
------------

// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel window scheduler:
//   PIX_W_DEFAULT - default pixel width in bits
//   WIN_W         - packed 3x3 window width for the default pixel width
//   state_e       - scheduler FSM states
//   SLOT_*        - window slot indices; slot s occupies bits [s*PIX_W +: PIX_W]
//   slot_idx()    - maps (column, row) inside the window to its slot
// ---------------------------------------------------------------------------
package sobel_pkg;

  localparam int PIX_W_DEFAULT = 8;
  localparam int WIN_W         = 9 * PIX_W_DEFAULT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  // Column-major, most significant slot first (engine bus order).
  localparam int SLOT_TL = 8;
  localparam int SLOT_ML = 7;
  localparam int SLOT_BL = 6;
  localparam int SLOT_TC = 5;
  localparam int SLOT_CC = 4;
  localparam int SLOT_BC = 3;
  localparam int SLOT_TR = 2;
  localparam int SLOT_MR = 1;
  localparam int SLOT_BR = 0;

  // col: 0=left..2=right, row: 0=top..2=bottom
  function automatic int slot_idx(input int col, input int row);
    return SLOT_TL - (3 * col + row);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// ---------------------------------------------------------------------------
// sobel_line_buffer
// One image line of pixels. Single port: the read at addr_i returns the value
// stored before this cycle's write, so a column can be read and replaced in
// the same cycle.
//   clk     - clock
//   we_i    - write enable
//   addr_i  - column address
//   wdata_i - pixel to store
//   rdata_o - pixel currently stored at addr_i (pre-write value)
// ---------------------------------------------------------------------------
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_scheduler.sv
// ---------------------------------------------------------------------------
// sobel_window_scheduler
// Accepts one raster-order frame as a pixel stream and issues one packed 3x3
// window per interior pixel to the Sobel engine.
//   clk       - rising-edge clock
//   reset     - asynchronous, active-low reset
//   start     - begins a frame when idle
//   busy      - high from accepted start until done
//   done      - one-cycle pulse after the last window handshake
//   pix_valid/pix_data/pix_ready - input pixel stream
//   win_valid/win_data/win_ready - output window stream
//   win_count - windows handshaked in the current or last frame (saturating)
// ---------------------------------------------------------------------------
module sobel_window_scheduler import sobel_pkg::*; #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               pix_ready,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  input  logic               win_ready,
  output logic [15:0]        win_count
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e                     state_q;
  logic [CW-1:0]              col_q;
  logic [RW-1:0]              row_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       win_valid_q;
  logic [9*PIX_W-1:0]         win_data_q;
  logic [15:0]                win_count_q;

  // Window shift register, indexed [column][row]; column 2 is the newest.
  logic [2:0][2:0][PIX_W-1:0] shift_q;
  logic [2:0][2:0][PIX_W-1:0] shift_d;
  logic [9*PIX_W-1:0]         win_pack_d;

  logic [PIX_W-1:0]           lb0_rd;
  logic [PIX_W-1:0]           lb1_rd;
  logic                       xfer;
  logic                       hs;
  logic                       win_load;

  assign pix_ready = (state_q == S_RUN) && (!win_valid_q || win_ready);
  assign xfer      = pix_valid && pix_ready;
  assign hs        = win_valid_q && win_ready;
  // Only pixels with two columns and two rows behind them close a window;
  // this also hides the stale columns left in shift_q across a row wrap.
  assign win_load  = xfer && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // lb0 holds the previous line, lb1 the one before it.
  sobel_line_buffer #(.DEPTH(IMG_W), .DW(PIX_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .we_i    (xfer),
    .addr_i  (col_q),
    .wdata_i (pix_data),
    .rdata_o (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .DW(PIX_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we_i    (xfer),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    shift_d       = shift_q;
    shift_d[0]    = shift_q[1];
    shift_d[1]    = shift_q[2];
    shift_d[2][0] = lb1_rd;
    shift_d[2][1] = lb0_rd;
    shift_d[2][2] = pix_data;
  end

  // The issued window is the post-shift content, so it includes this pixel.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_col
      for (gj = 0; gj < 3; gj++) begin : g_row
        assign win_pack_d[slot_idx(gi, gj)*PIX_W +: PIX_W] = shift_d[gi][gj];
      end
    end
  endgenerate

  // Window contents are fully overwritten before first use; no reset needed.
  always_ff @(posedge clk) begin
    if (xfer) begin
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_count_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (hs) begin
        win_valid_q <= 1'b0;
        if (win_count_q != 16'hFFFF) begin
          win_count_q <= win_count_q + 16'd1;
        end
      end

      // A new window overrides the handshake drop above: no bubble.
      if (win_load) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_pack_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            col_q       <= '0;
            row_q       <= '0;
            win_count_q <= '0;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!win_valid_q || hs) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_count = win_count_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_scheduler
// Directed bench for sobel_window_scheduler. Two instances share the pixel
// and window-ready inputs: a 4x4 frame scheduler and a 5x3 one. Each only
// consumes pixels while it is running, so sel picks which one is observed.
// ---------------------------------------------------------------------------
module tb_sobel_window_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start4 = 1'b0;
  logic        start5 = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        win_ready = 1'b1;

  logic        busy4, done4, pr4, wv4;
  logic [71:0] wd4;
  logic [15:0] wc4;
  logic        busy5, done5, pr5, wv5;
  logic [71:0] wd5;
  logic [15:0] wc5;

  int          sel = 0;
  logic        cur_busy, cur_done, cur_pr, cur_wv;
  logic [71:0] cur_wd;
  logic [15:0] cur_wc;

  logic [71:0] got[$];
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sobel_window_scheduler #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .busy      (busy4),
    .done      (done4),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pr4),
    .win_valid (wv4),
    .win_data  (wd4),
    .win_ready (win_ready),
    .win_count (wc4)
  );

  sobel_window_scheduler #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) dut5 (
    .clk       (clk),
    .reset     (reset),
    .start     (start5),
    .busy      (busy5),
    .done      (done5),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pr5),
    .win_valid (wv5),
    .win_data  (wd5),
    .win_ready (win_ready),
    .win_count (wc5)
  );

  always_comb begin
    cur_busy = (sel == 0) ? busy4 : busy5;
    cur_done = (sel == 0) ? done4 : done5;
    cur_pr   = (sel == 0) ? pr4   : pr5;
    cur_wv   = (sel == 0) ? wv4   : wv5;
    cur_wd   = (sel == 0) ? wd4   : wd5;
    cur_wc   = (sel == 0) ? wc4   : wc5;
  end

  // Window handshakes and done pulses of the observed instance.
  always @(negedge clk) begin
    if (cur_wv && win_ready) got.push_back(cur_wd);
    if (cur_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int w, input int base, input int r, input int c);
    logic [71:0] v = '0;
    for (int cc = 0; cc < 3; cc++) begin
      for (int rr = 0; rr < 3; rr++) begin
        v = {v[63:0], 8'(base + (r - 1 + rr) * w + (c - 1 + cc))};
      end
    end
    return v;
  endfunction

  task automatic pulse_start(input int s);
    sel = s;
    got.delete();
    done_cnt = 0;
    if (s == 0) start4 = 1'b1; else start5 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start5 = 1'b0;
    check("busy_after_start", cur_busy, 1);
  endtask

  // Sends npix pixels (value base+k). start_at re-pulses start while running;
  // lat checks the window one edge after each window-closing pixel.
  task automatic feed(input int w, input int base, input int npix, input bit rnd,
                      input int start_at, input bit lat);
    bit acc;
    int t;
    for (int k = 0; k < npix; k++) begin
      if (rnd) begin
        while ($urandom_range(1, 0) == 1) begin
          pix_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      pix_valid = 1'b1;
      pix_data  = 8'(base + k);
      if (k == start_at) begin
        if (sel == 0) start4 = 1'b1; else start5 = 1'b1;
      end
      t = 0;
      do begin
        @(negedge clk);
        acc = cur_pr;
        @(posedge clk); #1;
        start4 = 1'b0;
        start5 = 1'b0;
        t++;
      end while (!acc && t < 100);
      if (!acc) check("pix_accept_timeout", 0, 1);
      if (lat && (k / w) >= 2 && (k % w) >= 2) begin
        check("lat_valid", cur_wv, 1);
        check("lat_data", cur_wd, exp_win(w, base, k / w - 1, k % w - 1));
      end
    end
    pix_valid = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle after done (scheduler idle again).
  task automatic wait_done();
    int t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (cur_done) break;
      t++;
    end
    if (t >= 200) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int base);
    int n = (w - 2) * (h - 2);
    check({tag, "_nwin"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({tag, "_win"}, got[i], exp_win(w, base, 1 + i / (w - 2), 1 + i % (w - 2)));
    end
    check({tag, "_count"}, cur_wc, n);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_low"}, cur_busy, 0);
    $display("frame %s: %0d windows, win_count %0d", tag, got.size(), cur_wc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, cur_busy, 0);
    check({tag, "_done"}, cur_done, 0);
    check({tag, "_pix_ready"}, cur_pr, 0);
    check({tag, "_win_valid"}, cur_wv, 0);
    check({tag, "_win_data"}, cur_wd, 0);
    check({tag, "_win_count"}, cur_wc, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] held;
    int t;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: 4x4 frame, engine always ready
    pulse_start(0);
    feed(4, 0, 16, 0, -1, 1);
    wait_done();
    check_frame("t1", 4, 4, 0);
    if (got.size() == 4) begin
      check("t1_first", got[0], 72'h00_04_08_01_05_09_02_06_0A);
      check("t1_last", got[3], 72'h05_09_0D_06_0A_0E_07_0B_0F);
    end
    repeat (2) @(posedge clk);
    #1;

    // 2: engine stalls for 5 cycles while a window is pending
    pulse_start(0);
    fork
      feed(4, 0, 16, 0, -1, 0);
      begin
        t = 0;
        do begin
          @(posedge clk); #1;
          t++;
        end while (!cur_wv && t < 200);
        win_ready = 1'b0;
        held = cur_wd;
        repeat (5) begin
          @(negedge clk);
          check("t2_stall_pix_ready", cur_pr, 0);
          check("t2_stall_valid", cur_wv, 1);
          check("t2_stall_data", cur_wd, held);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
      end
    join
    wait_done();
    check_frame("t2", 4, 4, 0);
    repeat (2) @(posedge clk);
    #1;

    // 3: 5x3 frame with random pixel gaps
    pulse_start(1);
    feed(5, 0, 15, 1, -1, 0);
    wait_done();
    check_frame("t3", 5, 3, 0);
    repeat (2) @(posedge clk);
    #1;

    // 4: start re-pulsed mid-frame is ignored
    pulse_start(0);
    feed(4, 0, 16, 0, 12, 0);
    wait_done();
    check_frame("t4", 4, 4, 0);
    repeat (2) @(posedge clk);
    #1;

    // 5: reset after pixel 7, then a clean frame
    pulse_start(0);
    feed(4, 0, 8, 0, -1, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 0);
    check("t5_no_win", got.size(), 0);
    pulse_start(0);
    feed(4, 0, 16, 0, -1, 1);
    wait_done();
    check_frame("t5", 4, 4, 0);
    repeat (2) @(posedge clk);
    #1;

    // 6: back-to-back frames, second one with different pixel values
    pulse_start(0);
    feed(4, 0, 16, 0, -1, 0);
    wait_done();
    check_frame("t6a", 4, 4, 0);
    pulse_start(0);
    feed(4, 8'h40, 16, 0, -1, 1);
    wait_done();
    check_frame("t6b", 4, 4, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
